fx2_pipe: RTL and testbench
===========================

Name: fx2_pipe

Overview:
- Pipelined even-pipe FX2 execution stage of the SPU. Accepts one issued instruction per cycle and computes the 128-bit halfword/word rotate or shift-by-immediate result in stage 1.
- Carries the result, target register address and valid bit through LATENCY register stages to the register-file writeback port.
- Exposes every stage's contents as forwarding taps.
- Receives flushes from the branch unit.

Parameters:
- LATENCY, 4, number of pipeline register stages from issue to writeback (legal 2..7).

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all valid bits
- in_valid  in  1  issue slot holds an FX2 instruction this cycle
- in_op  in  3  [0:2] opcode select: 0 rothi, 1 roti, 2 shlhi, 3 shli, 4..7 illegal
- ra  in  128  [0:127] source operand, big-endian bit numbering
- imme7  in  7  [0:6] immediate count field
- in_rt  in  7  [0:6] target register address
- flush  in  1  kill younger in-flight instructions
- fwd_valid  out  LATENCY  bit k-1 = valid of stage k
- fwd_rt  out  7*LATENCY  stage k address at slice [7(k-1) +: 7]
- fwd_result  out  128*LATENCY  stage k result at slice [128(k-1) +: 128]
- wb_valid  out  1  valid of stage LATENCY
- wb_rt  out  7  target address of stage LATENCY
- wb_result  out  128  result of stage LATENCY

Behaviour:
- Reset: all stage valid bits 0, all stage rt and result registers 0. Consequently every output is 0 the cycle after reset.
- Reset dominates in_valid and flush.
- Stage 1 load: at an edge with in_valid=1, a legal op and flush=0, stage 1 captures:
  - valid=1
  - rt=in_rt
  - result = combinational compute of (ra, imme7, in_op)
- Otherwise stage 1 valid becomes 0; rt and result hold their old values (don't-care while invalid).
- Shift stages: stage k+1 takes stage k each edge. Latency: issued at edge E, appears on wb_* after edge E+LATENCY-1; issue-to-writeback is LATENCY cycles.
- No stall, no backpressure: one instruction per cycle sustained, no bubbles inserted.
- Illegal op (4..7) with in_valid=1: treated as a bubble (valid 0), no writeback.
- Bit numbering: halfword i = ra[16i : 16i+15], i=0..7; word i = ra[32i : 32i+31], i=0..3. Bit 0 is the MSB.
- rothi: s = imme7[3:6] (mod 16). For each halfword, r[b] = t[(b+s) mod 16] (rotate left toward bit 0).
- roti: s = imme7[2:6] (mod 32). Per word, r[b] = t[(b+s) mod 32].
- shlhi: s = imme7[2:6] (0..31). If s>15, halfword = 0. Else r[b] = t[b+s] when b+s<16, else 0.
- shli: s = imme7[1:6] (0..63). If s>31, word = 0. Else r[b] = t[b+s] when b+s<32, else 0.
- imme7 bits above the used field are ignored. Count 0 returns ra unchanged for all ops.
- Flush: at an edge with flush=1:
  - stages 1..LATENCY-1 become invalid, including any instruction being issued that cycle;
  - the instruction already in stage LATENCY (presented on wb_* during the flush cycle) is committed, not killed;
  - the new contents of stage LATENCY come from the killed stage LATENCY-1, so wb_valid=0 the next cycle.
- Back-to-back flushes are allowed. Flush during reset has no effect.
- Forwarding taps reflect registered stage contents only; no combinational path from inputs to outputs.

Test Plan:
1. Reset then single rothi: ra = 0x8001 repeated ×8, imme7 = 7'd1, in_rt = 5. Exactly 4 cycles after issue: wb_valid=1, wb_rt=5, wb_result = 0x0003 repeated ×8. Before and after that cycle wb_valid=0.
2. Op sweep on ra = 0x80000001 repeated ×4, count 7'd4:
   - roti → 0x00000018 per word;
   - shli → 0x00000010 per word;
   - shlhi → halfword pattern 0x0000,0x0010 repeated;
   - rothi with imme7 = 7'd20 (s=4) → 0x0008,0x0010 repeated.
3. Boundary counts on ra = all ones:
   - shlhi imme7=16 → all zero;
   - shli imme7=32 → all zero;
   - rothi imme7=0 → all ones;
   - roti imme7=32 → all ones (mod 32).
4. Throughput: issue 6 consecutive valid instructions with in_rt 1..6. wb_rt sequence is 1..6 on 6 consecutive cycles. fwd_valid shows 4'b1111 at steady state. Illegal op 5 injected mid-stream → one-cycle wb_valid=0 gap at the matching slot.
5. Flush: fill all 4 stages (rt 1..4, rt 1 oldest), then assert flush for one cycle while issuing rt 5. rt 1 is written back during the flush cycle. Next 4 cycles wb_valid=0, fwd_valid=0, and rt 5 never appears.
6. Reset mid-stream with pipeline full and in_valid=1: next cycle all fwd_valid=0, wb_valid=0, wb_rt=0, wb_result=0. The first issue after reset deasserts writes back 4 cycles later.

Source files
------------

// File: rtl/fx2_if.sv
// fx2_if: issue, flush, forwarding-tap and writeback signals of the FX2 stage.
interface fx2_if #(
    parameter int LATENCY = 4
);
    logic                      in_valid;
    logic [0:2]                in_op;
    logic [0:127]              ra;
    logic [0:6]                imme7;
    logic [0:6]                in_rt;
    logic                      flush;
    logic [LATENCY-1:0]        fwd_valid;
    logic [7*LATENCY-1:0]      fwd_rt;
    logic [128*LATENCY-1:0]    fwd_result;
    logic                      wb_valid;
    logic [0:6]                wb_rt;
    logic [0:127]              wb_result;

    modport master (
        output in_valid, in_op, ra, imme7, in_rt, flush,
        input  fwd_valid, fwd_rt, fwd_result, wb_valid, wb_rt, wb_result
    );
    modport slave (
        input  in_valid, in_op, ra, imme7, in_rt, flush,
        output fwd_valid, fwd_rt, fwd_result, wb_valid, wb_rt, wb_result
    );
endinterface

// File: rtl/fx2_pipe.sv
// fx2_pipe: SPU even-pipe FX2 halfword/word rotate and shift-by-immediate stage,
// LATENCY register stages to writeback with every stage exposed as a forwarding tap.
module fx2_pipe #(
    parameter int LATENCY = 4
) (
    input logic   clk,
    input logic   reset,
    fx2_if.slave  bus
);
    logic [0:127] rot_h, rot_w, shl_h, shl_w, res;
    logic         issue, unused_imm;
    logic [LATENCY-1:0] v;
    logic [0:6]   rt_q [LATENCY];
    logic [0:127] r_q  [LATENCY];

    assign unused_imm = bus.imme7[0];

    // Rotates take the upper half of a doubled lane shifted left; shifts past the lane width give 0.
    for (genvar i = 0; i < 8; i++) begin : g_half
        logic [15:0] h;
        logic [31:0] d;
        assign h = bus.ra[16*i +: 16];
        assign d = {h, h} << bus.imme7[3:6];
        assign rot_h[16*i +: 16] = d[31:16];
        assign shl_h[16*i +: 16] = h << bus.imme7[2:6];
    end

    for (genvar i = 0; i < 4; i++) begin : g_word
        logic [31:0] w;
        logic [63:0] d;
        assign w = bus.ra[32*i +: 32];
        assign d = {w, w} << bus.imme7[2:6];
        assign rot_w[32*i +: 32] = d[63:32];
        assign shl_w[32*i +: 32] = w << bus.imme7[1:6];
    end

    assign res = bus.in_op[1:2] == 2'd0 ? rot_h :
                 bus.in_op[1:2] == 2'd1 ? rot_w :
                 bus.in_op[1:2] == 2'd2 ? shl_h : shl_w;
    assign issue = bus.in_valid & ~bus.in_op[0] & ~bus.flush;

    // A flush kills stages 1..LATENCY-1, so every stage is invalid after the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            v <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                rt_q[k] <= '0;
                r_q[k]  <= '0;
            end
        end else begin
            v <= bus.flush ? '0 : {v[LATENCY-2:0], issue};
            if (issue) begin
                rt_q[0] <= bus.in_rt;
                r_q[0]  <= res;
            end
            for (int k = 1; k < LATENCY; k++) begin
                rt_q[k] <= rt_q[k-1];
                r_q[k]  <= r_q[k-1];
            end
        end
    end

    for (genvar k = 0; k < LATENCY; k++) begin : g_tap
        assign bus.fwd_rt[7*k +: 7]         = rt_q[k];
        assign bus.fwd_result[128*k +: 128] = r_q[k];
    end

    assign bus.fwd_valid = v;
    assign bus.wb_valid  = v[LATENCY-1];
    assign bus.wb_rt     = rt_q[LATENCY-1];
    assign bus.wb_result = r_q[LATENCY-1];
endmodule

// File: tb/tb_fx2_pipe.sv
// tb_fx2_pipe: scoreboard bench for fx2_pipe; expected writebacks are queued with the
// cycle they are due and a negedge monitor compares writeback and forwarding taps.
module tb_fx2_pipe;
    localparam int L = 4;

    logic clk = 0;
    logic reset = 1;
    always #5 clk = ~clk;

    fx2_if #(.LATENCY(L)) bus();
    fx2_pipe #(.LATENCY(L)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        int           due;
        logic [6:0]   rt;
        logic [127:0] res;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   armed = 0;

    localparam logic [127:0] ONES = '1;

    // Bit-by-bit evaluation of the rules with bit 0 as the MSB of the operand.
    function automatic logic [127:0] ref_calc(input logic [2:0] op, input logic [127:0] a, input logic [6:0] imm);
        logic [0:127] t, r;
        int n, s, base, o;
        t = a;
        n = (op == 3'd0 || op == 3'd2) ? 16 : 32;
        s = op == 3'd0 ? imm % 16 : op == 3'd3 ? imm % 64 : imm % 32;
        for (int b = 0; b < 128; b++) begin
            base = (b / n) * n;
            o = b % n;
            if (op < 3'd2) r[b] = t[base + (o + s) % n];
            else r[b] = (o + s < n) ? t[base + o + s] : 1'b0;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [1023:0] got, input logic [1023:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic step(input bit v, input logic [2:0] op, input logic [127:0] a, input logic [6:0] imm,
                        input logic [6:0] rt, input bit fl = 0, input bit rs = 0,
                        input bit ovr = 0, input logic [127:0] ex = '0);
        exp_t e;
        bus.in_valid = v;
        bus.in_op = op;
        bus.ra = a;
        bus.imme7 = imm;
        bus.in_rt = rt;
        bus.flush = fl;
        reset = rs;
        @(posedge clk);
        #1;
        cyc++;
        if (rs || fl) begin
            while (q.size() > 0 && q[q.size()-1].due >= cyc) void'(q.pop_back());
        end else if (v && op < 3'd4) begin
            e.due = cyc + L - 1;
            e.rt = rt;
            e.res = ovr ? ex : ref_calc(op, a, imm);
            q.push_back(e);
        end
        if (rs) armed = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 3'd0, '0, '0, '0);
    endtask

    // Stage k holds whichever queued instruction is due at writeback L-k cycles from now.
    always @(negedge clk) begin
        logic [L-1:0] ev;
        int st;
        if (armed) begin
            ev = '0;
            foreach (q[j]) begin
                st = L - (q[j].due - cyc);
                if (st >= 1 && st <= L) begin
                    ev[st-1] = 1'b1;
                    checks++;
                    if (bus.fwd_rt[7*(st-1) +: 7] !== q[j].rt || bus.fwd_result[128*(st-1) +: 128] !== q[j].res) begin
                        errors++;
                        $display("FAIL fwd_tap stage %0d cyc %0d got rt %0d res %0h expected rt %0d res %0h", st, cyc,
                                 bus.fwd_rt[7*(st-1) +: 7], bus.fwd_result[128*(st-1) +: 128], q[j].rt, q[j].res);
                    end
                end
            end
            checks++;
            if (bus.fwd_valid !== ev) begin
                errors++;
                $display("FAIL fwd_valid cyc %0d got %b expected %b", cyc, bus.fwd_valid, ev);
            end
            checks++;
            if (q.size() > 0 && q[0].due == cyc) begin
                if (bus.wb_valid !== 1'b1 || bus.wb_rt !== q[0].rt || bus.wb_result !== q[0].res) begin
                    errors++;
                    $display("FAIL writeback cyc %0d got v %b rt %0d res %0h expected v 1 rt %0d res %0h", cyc,
                             bus.wb_valid, bus.wb_rt, bus.wb_result, q[0].rt, q[0].res);
                end
                void'(q.pop_front());
            end else if (bus.wb_valid !== 1'b0) begin
                errors++;
                $display("FAIL spurious_wb cyc %0d got v %b rt %0d expected v 0", cyc, bus.wb_valid, bus.wb_rt);
            end
        end
    end

    initial begin
        logic [127:0] a;
        step(0, 3'd0, '0, '0, '0, 0, 1);
        step(0, 3'd0, '0, '0, '0, 0, 1);
        chk("reset_wb_valid", {1023'b0, bus.wb_valid}, '0);
        chk("reset_wb_rt", {1017'b0, bus.wb_rt}, '0);
        chk("reset_wb_result", {896'b0, bus.wb_result}, '0);
        chk("reset_fwd_rt", {996'b0, bus.fwd_rt}, '0);
        chk("reset_fwd_result", {512'b0, bus.fwd_result}, '0);

        step(1, 3'd0, {8{16'h8001}}, 7'd1, 7'd5, 0, 0, 1, {8{16'h0003}});
        idle(6);

        a = {4{32'h80000001}};
        step(1, 3'd1, a, 7'd4, 7'd10, 0, 0, 1, {4{32'h00000018}});
        step(1, 3'd3, a, 7'd4, 7'd11, 0, 0, 1, {4{32'h00000010}});
        step(1, 3'd2, a, 7'd4, 7'd12, 0, 0, 1, {4{32'h00000010}});
        step(1, 3'd0, a, 7'd20, 7'd13, 0, 0, 1, {4{32'h00080010}});
        step(1, 3'd2, ONES, 7'd16, 7'd20, 0, 0, 1, '0);
        step(1, 3'd3, ONES, 7'd32, 7'd21, 0, 0, 1, '0);
        step(1, 3'd0, ONES, 7'd0, 7'd22, 0, 0, 1, ONES);
        step(1, 3'd1, ONES, 7'd32, 7'd23, 0, 0, 1, ONES);
        idle(6);

        for (int i = 1; i <= 6; i++) begin
            if (i == 4) step(1, 3'd5, {4{$urandom}}, 7'($urandom), 7'd99);
            step(1, 3'($urandom_range(0, 3)), {4{$urandom}}, 7'($urandom), 7'(i));
        end
        idle(6);

        for (int i = 1; i <= 4; i++) step(1, 3'd1, {4{$urandom}}, 7'($urandom), 7'(i));
        step(1, 3'd1, {4{$urandom}}, 7'd3, 7'd5, 1);
        idle(6);

        for (int i = 1; i <= 4; i++) step(1, 3'd3, {4{$urandom}}, 7'($urandom), 7'(i + 40));
        step(1, 3'd3, {4{$urandom}}, 7'd1, 7'd45, 0, 1);
        chk("midreset_fwd_valid", {1019'b0, bus.fwd_valid}, '0);
        chk("midreset_wb_valid", {1023'b0, bus.wb_valid}, '0);
        chk("midreset_wb_rt", {1017'b0, bus.wb_rt}, '0);
        chk("midreset_wb_result", {896'b0, bus.wb_result}, '0);
        step(1, 3'd2, {4{$urandom}}, 7'd3, 7'd46);
        idle(6);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), {$urandom, $urandom, $urandom, $urandom},
                 7'($urandom), 7'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
        idle(L + 3);
        chk("drain_empty", 1024'(q.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
